// File: rtl/cbus_rr_arbiter.sv
// ============================================================================
// Module   : cbus_rr_arbiter
// Purpose  : Round-robin arbiter merging NUM_INPUTS cbus masters onto one
//            cbus slave port; the grant is held until the last burst beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  cbus_req_t        ireqs  [NUM_INPUTS],
  output cbus_resp_t       iresps [NUM_INPUTS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_INPUTS-1:0]   req_valid;
  logic [2*NUM_INPUTS-1:0] valid_dbl;
  logic [NUM_INPUTS-1:0]   valid_rot;
  logic                    any_valid;
  logic [IDX_W-1:0]        winner;
  logic                    burst_done;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int               off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_INPUTS) sum = sum - NUM_INPUTS;
    return IDX_W'(sum);
  endfunction

  generate
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_valid
      assign req_valid[i] = ireqs[i].valid;
    end
  endgenerate

  // Rotate the valid vector so bit 0 is the master at rr_ptr.
  assign valid_dbl = {req_valid, req_valid};
  assign valid_rot = valid_dbl[rr_ptr_q +: NUM_INPUTS];

  always_comb begin
    any_valid = 1'b0;
    winner    = rr_ptr_q;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        any_valid = 1'b1;
        winner    = wrap_add(rr_ptr_q, k);
      end
    end
  end

  assign burst_done = oresp.ready && oresp.last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (burst_done) begin
          state_d  = IDLE;
          rr_ptr_d = wrap_add(grant_q, 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == BUSY);
  assign grant_idx = grant_q;
  assign oreq      = busy ? ireqs[grant_q] : '0;

  generate
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_resp
      assign iresps[i] = (busy && (grant_q == IDX_W'(i))) ? oresp : '0;
    end
  endgenerate

endmodule

`default_nettype wire
